// File: rtl/ram_sized_mfa.sv
// Clocked big-endian byte/halfword/word RAM with programmable wait states and a four-phase mv/moc handshake.
// Define RAM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses and flag them on align_err.
module ram_sized_mfa #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mv,
    input  logic              rw,
    input  logic [1:0]        typeData,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       DaIn,
    output logic [31:0]       DaOut,
    output logic              moc,
    output logic              busy,
    output logic              align_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [1:0]        type_q, type_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       dout_q, dout_d;
    logic              moc_q, moc_d;
    logic              aerr_q, aerr_d;

    logic [7:0]        mem [DEPTH];

    logic              commit;
    logic              misaligned;
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [31:0]       rdata;

    // Byte offsets wrap naturally through the ADDR_W-bit width.
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

`ifdef RAM_ALIGN_CHECK_EN
    assign misaligned = ((type_q == 2'b01) && addr_q[0]) ||
                        ((type_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (type_q)
            2'b00:   rdata = {24'h0, mem[addr_q]};
            2'b01:   rdata = {16'h0, mem[addr_q], mem[a1]};
            2'b10:   rdata = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        type_d  = type_q;
        din_d   = din_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        aerr_d  = aerr_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mv) begin
                    addr_d  = address;
                    rw_d    = rw;
                    type_d  = typeData;
                    din_d   = DaIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Abort wins over a commit that would fall on the same edge.
                if (!mv) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    moc_d   = 1'b1;
                    aerr_d  = misaligned;
                    state_d = DONE;
                    if (rw_q && !misaligned && (type_q != 2'b11))
                        dout_d = rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!mv) begin
                    moc_d   = 1'b0;
                    aerr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            type_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            type_q  <= type_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            aerr_q  <= aerr_d;
        end
    end

    // Storage is never cleared; reset only suppresses a commit on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && commit && !rw_q && !misaligned) begin
            case (type_q)
                2'b00: mem[addr_q] <= din_q[7:0];
                2'b01: begin
                    mem[addr_q] <= din_q[15:8];
                    mem[a1]     <= din_q[7:0];
                end
                2'b10: begin
                    mem[addr_q] <= din_q[31:24];
                    mem[a1]     <= din_q[23:16];
                    mem[a2]     <= din_q[15:8];
                    mem[a3]     <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    assign DaOut     = dout_q;
    assign moc       = moc_q;
    assign busy      = (state_q != IDLE);
    assign align_err = aerr_q;

endmodule

// File: tb/tb_ram_sized_mfa.sv
// Self-checking bench for ram_sized_mfa: directed vector table, handshake corner cases and
// randomized accesses against a byte-array reference model.
module tb_ram_sized_mfa;

    localparam int unsigned WC = 2;
`ifdef RAM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mv;
    logic        rw;
    logic [1:0]  typeData;
    logic [7:0]  address;
    logic [31:0] DaIn;
    logic [31:0] DaOut;
    logic        moc;
    logic        busy;
    logic        align_err;

    ram_sized_mfa #(.ADDR_W(8), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .mv(mv), .rw(rw), .typeData(typeData),
        .address(address), .DaIn(DaIn), .DaOut(DaOut), .moc(moc),
        .busy(busy), .align_err(align_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  ref_mem [256];
    logic [31:0] ref_dout;
    logic        ref_aerr;

    typedef struct {
        logic        r;
        logic [1:0]  t;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_dout;
        logic        exp_aerr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [1:0] t, input logic [7:0] a);
        if (!ALIGN) return 1'b0;
        return (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00);
    endfunction

    task automatic ref_access(input logic r, input logic [1:0] t, input logic [7:0] a,
                              input logic [31:0] d);
        int unsigned nb;
        logic [31:0] v;
        logic [7:0]  idx;
        ref_aerr = is_misaligned(t, a);
        if (ref_aerr || t == 2'b11) return;
        nb = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
        v = '0;
        for (int unsigned k = 0; k < nb; k++) begin
            idx = a + 8'(k);
            if (!r) ref_mem[idx] = d[8*(nb-1-k) +: 8];
            else    v = (v << 8) | {24'h0, ref_mem[idx]};
        end
        if (r) ref_dout = v;
    endtask

    // Full four-phase transaction; inputs are scrambled after the request edge.
    task automatic access(input logic r, input logic [1:0] t, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] dout, output logic aerr);
        int lat;
        @(negedge clk);
        mv = 1'b1; rw = r; typeData = t; address = a; DaIn = d;
        @(posedge clk); #1;
        check("busy_after_req", busy, 1'b1);
        check("moc_after_req", moc, 1'b0);
        rw = ~r; typeData = 2'($urandom); address = 8'($urandom); DaIn = $urandom;
        lat = 0;
        while (!moc && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("moc_latency", 32'(lat), 32'(WC + 1));
        check("busy_in_done", busy, 1'b1);
        dout = DaOut;
        aerr = align_err;
        @(posedge clk); #1;
        check("moc_held", moc, 1'b1);
        check("aerr_held", align_err, aerr);
        mv = 1'b0;
        @(posedge clk); #1;
        check("moc_released", moc, 1'b0);
        check("busy_released", busy, 1'b0);
        check("aerr_released", align_err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got_d;
        logic        got_e;
        logic        r;
        logic [1:0]  t;
        logic [7:0]  a;
        logic [31:0] d;

        reset = 1'b1; mv = 1'b0; rw = 1'b0; typeData = '0; address = '0; DaIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", DaOut, 32'h0);
        check("reset_moc", moc, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_aerr", align_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ref_dout = '0;

        for (int i = 0; i < 256; i++) begin
            ref_access(1'b0, 2'b00, 8'(i), 32'(i));
            access(1'b0, 2'b00, 8'(i), 32'(i), got_d, got_e);
        end

        vecs[0]  = '{1'b1, 2'b10, 8'h04, 32'h0,        32'h04050607, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 8'h02, 32'h0000009B, 32'h04050607, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 8'h02, 32'h0,        32'h00009B03, 1'b0};
        vecs[3]  = '{1'b0, 2'b10, 8'h08, 32'hBEBEBEBF, 32'h00009B03, 1'b0};
        vecs[4]  = '{1'b1, 2'b00, 8'h08, 32'h0,        32'h000000BE, 1'b0};
        vecs[5]  = '{1'b1, 2'b00, 8'h09, 32'h0,        32'h000000BE, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 8'h0A, 32'h0,        32'h000000BE, 1'b0};
        vecs[7]  = '{1'b1, 2'b00, 8'h0B, 32'h0,        32'h000000BF, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 8'hFE, 32'h11223344, 32'h000000BF, ALIGN};
        vecs[9]  = '{1'b1, 2'b00, 8'hFE, 32'h0, ALIGN ? 32'hFE : 32'h11, 1'b0};
        vecs[10] = '{1'b1, 2'b00, 8'hFF, 32'h0, ALIGN ? 32'hFF : 32'h22, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 8'h00, 32'h0, ALIGN ? 32'h00 : 32'h33, 1'b0};
        vecs[12] = '{1'b1, 2'b00, 8'h01, 32'h0, ALIGN ? 32'h01 : 32'h44, 1'b0};
        vecs[13] = '{1'b1, 2'b11, 8'h04, 32'h0, ALIGN ? 32'h01 : 32'h44, 1'b0};
        vecs[14] = '{1'b1, 2'b01, 8'h03, 32'h0, ALIGN ? 32'h01 : 32'h0304, ALIGN};
        vecs[15] = '{1'b1, 2'b10, 8'h05, 32'h0, ALIGN ? 32'h01 : 32'h050607BE, ALIGN};

        for (int i = 0; i < 16; i++) begin
            ref_access(vecs[i].r, vecs[i].t, vecs[i].a, vecs[i].d);
            access(vecs[i].r, vecs[i].t, vecs[i].a, vecs[i].d, got_d, got_e);
            check($sformatf("vec%0d_dout", i), got_d, vecs[i].exp_dout);
            check($sformatf("vec%0d_aerr", i), got_e, vecs[i].exp_aerr);
        end

        // Abort: mv dropped after one wait cycle on a write of 0xAA to 0x10.
        @(negedge clk);
        mv = 1'b1; rw = 1'b0; typeData = 2'b00; address = 8'h10; DaIn = 32'hAA;
        @(posedge clk); #1;
        check("abort_busy_req", busy, 1'b1);
        @(posedge clk); #1;
        check("abort_moc_wait", moc, 1'b0);
        mv = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_fall", busy, 1'b0);
        check("abort_moc_low", moc, 1'b0);
        access(1'b1, 2'b00, 8'h10, 32'h0, got_d, got_e);
        ref_access(1'b1, 2'b00, 8'h10, 32'h0);
        check("abort_mem_kept", got_d, 32'h10);

        // Reset on the commit edge of a write to 0x20.
        @(negedge clk);
        mv = 1'b1; rw = 1'b0; typeData = 2'b00; address = 8'h20; DaIn = 32'h55;
        @(posedge clk);
        repeat (WC) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstcommit_moc", moc, 1'b0);
        check("rstcommit_busy", busy, 1'b0);
        check("rstcommit_dout", DaOut, 32'h0);
        reset = 1'b0; mv = 1'b0;
        ref_dout = '0;
        access(1'b1, 2'b00, 8'h20, 32'h0, got_d, got_e);
        ref_access(1'b1, 2'b00, 8'h20, 32'h0);
        check("rstcommit_mem_kept", got_d, 32'h20);

        for (int i = 0; i < 250; i++) begin
            r = 1'($urandom);
            t = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
            d = $urandom;
            ref_access(r, t, a, d);
            access(r, t, a, d, got_d, got_e);
            check($sformatf("rnd%0d_dout", i), got_d, ref_dout);
            check($sformatf("rnd%0d_aerr", i), got_e, ref_aerr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
